// File: rtl/axi_slave_ram_if.sv
// ---------------------------------------------------------------------------
// axi_slave_ram_if
// Bundle of the five AXI channels (AW, W, B, AR, R) used by axi_slave_ram.
// Only the INCR / full-width subset is carried: no size, burst, lock, cache,
// prot or user fields.
//   AW : awid, awaddr, awlen, awvalid, awready
//   W  : wdata, wstrb, wlast, wvalid, wready
//   B  : bid, bresp, bvalid, bready
//   AR : arid, araddr, arlen, arvalid, arready
//   R  : rid, rdata, rresp, rlast, rvalid, rready
// Modports: slave (the RAM side) and master (the requester side).
// ---------------------------------------------------------------------------
interface axi_slave_ram_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]       awid;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                awlen;
  logic                      awvalid;
  logic                      awready;

  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [ID_WIDTH-1:0]       arid;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [7:0]                arlen;
  logic                      arvalid;
  logic                      arready;

  logic [ID_WIDTH-1:0]       rid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// ---------------------------------------------------------------------------
// axi_slave_ram
// AXI slave backed by a MEM_DEPTH x DATA_WIDTH RAM. INCR bursts of full-width
// beats only; the word index is the byte address with the in-word offset
// dropped, advancing by one per beat. Independent write and read FSMs.
// Ports:
//   aclk    : single clock, all state changes on its rising edge
//   aresetn : asynchronous active-low reset (RAM contents are kept)
//   s_axi   : axi_slave_ram_if.slave channel bundle
// Errors: a beat outside the RAM, or wlast disagreeing with the beat count,
// yields SLVERR (2'b10); out-of-range read beats return zero data.
// ---------------------------------------------------------------------------
module axi_slave_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_slave_ram_if.slave   s_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] L_DEPTH = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] L_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // write side state
  w_state_e              r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [7:0]            r_wcnt;
  logic                  r_werr;

  // read side state; r_ridx is the index of the beat to load next
  r_state_e              r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_ridx;
  logic [7:0]            r_rcnt;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_wlast_exp;
  logic                  w_w_inrange;
  logic                  w_beat_err;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic [ADDR_WIDTH-1:0] w_aw_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_rd_inrange;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_aw_hs     = s_axi.awvalid & r_awready;
  assign w_w_hs      = s_axi.wvalid & r_wready;
  // The burst ends on the beat count; wlast is only cross-checked.
  assign w_wlast_exp = (r_wcnt == 8'd0);
  assign w_w_inrange = (r_widx < L_DEPTH);
  assign w_beat_err  = (s_axi.wlast != w_wlast_exp) | ~w_w_inrange;
  assign w_aw_idx    = s_axi.awaddr >> OFS;

  assign w_ar_hs      = s_axi.arvalid & r_arready;
  assign w_r_hs       = r_rvalid & s_axi.rready;
  // In idle the first beat is loaded straight from araddr.
  assign w_rd_idx     = (r_rstate == R_IDLE) ? (s_axi.araddr >> OFS) : r_ridx;
  assign w_rd_inrange = (w_rd_idx < L_DEPTH);
  assign w_rd_word    = w_rd_inrange ? r_mem[w_rd_idx[MEM_AW-1:0]]
                                     : {DATA_WIDTH{1'b0}};

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.bid     = r_bid;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;

  // RAM byte-lane write for each accepted in-range W beat
  always_ff @(posedge aclk) begin
    if (w_w_hs && w_w_inrange) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) begin
          r_mem[r_widx[MEM_AW-1:0]][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM: address latch, beat counting, error accumulation, response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_bid     <= {ID_WIDTH{1'b0}};
      r_widx    <= {ADDR_WIDTH{1'b0}};
      r_wcnt    <= 8'd0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_bid     <= s_axi.awid;
            r_widx    <= w_aw_idx;
            r_wcnt    <= s_axi.awlen;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end else begin
            // awready comes up on the first edge after reset release
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx <= r_widx + L_ONE;
            r_wcnt <= r_wcnt - 8'd1;
            if (w_wlast_exp) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr | w_beat_err) ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end else begin
              r_werr <= r_werr | w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready && r_bvalid) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_wstate  <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: registered data beat, held until accepted, then next loaded
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rid     <= {ID_WIDTH{1'b0}};
      r_rdata   <= {DATA_WIDTH{1'b0}};
      r_ridx    <= {ADDR_WIDTH{1'b0}};
      r_rcnt    <= 8'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rid     <= s_axi.arid;
            r_rdata   <= w_rd_word;
            r_rresp   <= w_rd_inrange ? 2'b00 : 2'b10;
            r_rlast   <= (s_axi.arlen == 8'd0);
            r_rcnt    <= s_axi.arlen;
            r_ridx    <= w_rd_idx + L_ONE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rdata <= w_rd_word;
              r_rresp <= w_rd_inrange ? 2'b00 : 2'b10;
              // r_rcnt still counts the beat just accepted
              r_rlast <= (r_rcnt == 8'd1);
              r_rcnt  <= r_rcnt - 8'd1;
              r_ridx  <= r_ridx + L_ONE;
            end
          end
        end
        default: begin
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
          r_rstate  <= R_IDLE;
        end
      endcase
    end
  end

endmodule
